// File: rtl/ckbuf_array_div_gate.sv
// rtl/ckbuf_array_div_gate.sv - multi-channel programmable-ratio clock-enable strobe tile
module ckbuf_array_div_gate #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIV_RESET   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ckbuf_in,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   cfg_div,
    input  logic [NUM_CH-1:0]             cfg_load,
    output logic [NUM_CH-1:0]             ckbuf_out,
    output logic [NUM_CH-1:0]             ckbuf_ack,
    output logic                          ckbuf_busy
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_RESET);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] ack_d;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= ckbuf_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            state_e                 state_q, state_d;
            logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
            logic [DIV_WIDTH-1:0]   active_q, active_d;
            logic [DIV_WIDTH-1:0]   shadow_q, shadow_d;
            logic                   pulse_q, pulse_d;
            logic                   ack_q;
            logic                   tc;

            assign tc = (cnt_q == active_q);

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                active_d = active_q;
                // Shadow is the only thing cfg_load touches; active picks it up at the next boundary.
                shadow_d = cfg_load[g] ? cfg_div[g*DIV_WIDTH +: DIV_WIDTH] : shadow_q;
                pulse_d  = 1'b0;
                case (state_q)
                    ST_OFF: begin
                        cnt_d = '0;
                        if (s[g]) state_d = ST_ARM;
                    end
                    ST_ARM: begin
                        active_d = shadow_q;
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                    ST_RUN: begin
                        pulse_d = tc;
                        if (tc) begin
                            cnt_d    = '0;
                            active_d = shadow_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (!s[g]) state_d = ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        pulse_d = tc;
                        if (tc) begin
                            cnt_d    = '0;
                            active_d = shadow_q;
                            state_d  = s[g] ? ST_RUN : ST_OFF;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            if (s[g]) state_d = ST_RUN;
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign ack_d[g] = (state_d == ST_RUN) || (state_d == ST_DRAIN);

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q  <= ST_OFF;
                    cnt_q    <= '0;
                    active_q <= DIV_RST;
                    shadow_q <= DIV_RST;
                    pulse_q  <= 1'b0;
                    ack_q    <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    active_q <= active_d;
                    shadow_q <= shadow_d;
                    pulse_q  <= pulse_d;
                    ack_q    <= ack_d[g];
                end
            end

            assign ckbuf_out[g] = pulse_q;
            assign ckbuf_ack[g] = ack_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |ack_d;
        end
    end

    assign ckbuf_busy = busy_q;

endmodule

// File: tb/tb_ckbuf_array_div_gate.sv
// tb/tb_ckbuf_array_div_gate.sv - directed self-checking bench for ckbuf_array_div_gate
module tb_ckbuf_array_div_gate;

    logic        clk;
    logic        reset;
    logic [3:0]  ckbuf_in;
    logic [31:0] cfg_div;
    logic [3:0]  cfg_load;
    logic [3:0]  ckbuf_out;
    logic [3:0]  ckbuf_ack;
    logic        ckbuf_busy;

    int nvec;
    int nmis;

    ckbuf_array_div_gate dut (
        .clk        (clk),
        .reset      (reset),
        .ckbuf_in   (ckbuf_in),
        .cfg_div    (cfg_div),
        .cfg_load   (cfg_load),
        .ckbuf_out  (ckbuf_out),
        .ckbuf_ack  (ckbuf_ack),
        .ckbuf_busy (ckbuf_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ckbuf_in = '0;
        cfg_div  = '0;
        cfg_load = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            nvec++;
            if (ckbuf_out !== 4'b0 || ckbuf_ack !== 4'b0 || ckbuf_busy !== 1'b0) begin
                nmis++;
                $display("FAIL reset_idle t=%0d got out=%b ack=%b busy=%b exp out=0000 ack=0000 busy=0",
                         t, ckbuf_out, ckbuf_ack, ckbuf_busy);
            end
        end
    endtask

    task automatic test_div3_run();
        logic exp_out, exp_ack;
        cfg_div  = 32'h0000_0003;
        cfg_load = 4'b0001;
        tick();
        cfg_load = 4'b0000;
        ckbuf_in[0] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            exp_ack = (t >= 4);
            exp_out = (t >= 8) && (((t - 8) % 4) == 0);
            nvec++;
            if (ckbuf_out[0] !== exp_out || ckbuf_ack[0] !== exp_ack || ckbuf_busy !== exp_ack) begin
                nmis++;
                $display("FAIL div3_run t=%0d got out=%b ack=%b busy=%b exp out=%b ack=%b busy=%b",
                         t, ckbuf_out[0], ckbuf_ack[0], ckbuf_busy, exp_out, exp_ack, exp_ack);
            end
        end
    endtask

    task automatic test_drain();
        logic exp_out, exp_ack;
        ckbuf_in[0] = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            exp_out = (t == 4);
            exp_ack = (t < 4);
            nvec++;
            if (ckbuf_out !== {3'b0, exp_out} || ckbuf_ack !== {3'b0, exp_ack} || ckbuf_busy !== exp_ack) begin
                nmis++;
                $display("FAIL drain t=%0d got out=%b ack=%b busy=%b exp out=%b ack=%b busy=%b",
                         t, ckbuf_out, ckbuf_ack, ckbuf_busy, {3'b0, exp_out}, {3'b0, exp_ack}, exp_ack);
            end
        end
    endtask

    task automatic test_load_on_tc();
        logic exp_out, exp_ack;
        ckbuf_in[0] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            exp_ack = (t >= 4);
            exp_out = (t == 8) || (t >= 12);
            nvec++;
            if (ckbuf_out[0] !== exp_out || ckbuf_ack[0] !== exp_ack) begin
                nmis++;
                $display("FAIL load_on_tc t=%0d got out=%b ack=%b exp out=%b ack=%b",
                         t, ckbuf_out[0], ckbuf_ack[0], exp_out, exp_ack);
            end
            if (t == 7) begin
                cfg_div  = 32'h0000_0000;
                cfg_load = 4'b0001;
            end
            if (t == 8) cfg_load = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_period();
        logic [3:0] exp_out, exp_ack;
        ckbuf_in = 4'b0000;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        cfg_div  = {4{8'd3}};
        cfg_load = 4'hF;
        tick();
        cfg_load = 4'h0;
        ckbuf_in = 4'hF;
        for (int t = 1; t <= 6; t++) begin
            tick();
            exp_ack = (t >= 4) ? 4'hF : 4'h0;
            nvec++;
            if (ckbuf_out !== 4'h0 || ckbuf_ack !== exp_ack) begin
                nmis++;
                $display("FAIL all_ch_start t=%0d got out=%b ack=%b exp out=0000 ack=%b",
                         t, ckbuf_out, ckbuf_ack, exp_ack);
            end
        end
        ckbuf_in = 4'b0001;
        reset    = 1'b1;
        tick();
        nvec++;
        if (ckbuf_out !== 4'h0 || ckbuf_ack !== 4'h0 || ckbuf_busy !== 1'b0) begin
            nmis++;
            $display("FAIL reset_mid got out=%b ack=%b busy=%b exp out=0000 ack=0000 busy=0",
                     ckbuf_out, ckbuf_ack, ckbuf_busy);
        end
        reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp_ack = (t >= 4) ? 4'b0001 : 4'b0000;
            exp_out = (t >= 5) ? 4'b0001 : 4'b0000;
            nvec++;
            if (ckbuf_out !== exp_out || ckbuf_ack !== exp_ack || ckbuf_busy !== (exp_ack != 4'b0)) begin
                nmis++;
                $display("FAIL restart t=%0d got out=%b ack=%b busy=%b exp out=%b ack=%b",
                         t, ckbuf_out, ckbuf_ack, ckbuf_busy, exp_out, exp_ack);
            end
        end
    endtask

    task automatic test_max_div_glitch();
        logic [3:0] exp_out, exp_ack;
        ckbuf_in = 4'b0000;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        cfg_div  = 32'h0000_FF00;
        cfg_load = 4'b0010;
        tick();
        cfg_load = 4'b0000;
        ckbuf_in = 4'b0010;
        for (int t = 1; t <= 800; t++) begin
            tick();
            exp_out = (t == 260 || t == 516 || t == 772) ? 4'b0010 : 4'b0000;
            exp_ack = (t >= 4 && t < 772) ? 4'b0010 : 4'b0000;
            nvec++;
            if (ckbuf_out !== exp_out || ckbuf_ack !== exp_ack) begin
                nmis++;
                $display("FAIL div255 t=%0d got out=%b ack=%b exp out=%b ack=%b",
                         t, ckbuf_out, ckbuf_ack, exp_out, exp_ack);
            end
            if (t == 516) ckbuf_in = 4'b0000;
            if (t == 526) ckbuf_in = 4'b0010;
            if (t == 527) ckbuf_in = 4'b0000;
        end
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        test_reset();
        test_div3_run();
        test_drain();
        test_load_on_tc();
        test_reset_mid_period();
        test_max_div_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
